// File: rtl/cmplx_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cmplx_mul_seq
//  Description : Four-cycle complex multiplier sequencer. Computes
//                (a+jb)*(c+jd) on one shared unsigned WxW multiplier:
//                re = a*c - b*d (signed), im = a*d + b*c (unsigned).
//                Valid/ready handshakes on both the operand and result sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmplx_mul_seq #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    // operand side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W-1:0]     in_c,
    input  logic [W-1:0]     in_d,
    // shared multiplier
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_p,
    // result side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W:0]     out_re,
    output logic [2*W:0]     out_im,
    output logic             busy
);

    // Sequencer states; one multiply per state, DONE holds the result.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M_AC = 3'd1,
        S_M_BD = 3'd2,
        S_M_AD = 3'd3,
        S_M_BC = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_state_next;

    // Latched operands: in_* are free to change once accepted.
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_c;
    logic [W-1:0]   r_d;

    // Accumulators are 2W+1 bits: re spans +/-(2^W-1)^2, im up to 2*(2^W-1)^2.
    logic [2*W:0]   r_acc_re;
    logic [2*W:0]   r_acc_im;

    logic           w_accept;
    logic [2*W:0]   w_prod_ext;

    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_prod_ext = {1'b0, mul_p};

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the state-derived handshake and multiplier outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        mul_a        = '0;
        mul_b        = '0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = S_M_AC;
                end
            end
            S_M_AC: begin
                mul_a        = r_a;
                mul_b        = r_c;
                w_state_next = S_M_BD;
            end
            S_M_BD: begin
                mul_a        = r_b;
                mul_b        = r_d;
                w_state_next = S_M_AD;
            end
            S_M_AD: begin
                mul_a        = r_a;
                mul_b        = r_d;
                w_state_next = S_M_BC;
            end
            S_M_BC: begin
                mul_a        = r_b;
                mul_b        = r_c;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
            r_d <= '0;
        end else if (w_accept) begin
            r_a <= in_a;
            r_b <= in_b;
            r_c <= in_c;
            r_d <= in_d;
        end
    end

    // Accumulate partial products; the multiplier result is sampled at the
    // end of each multiply state. Subtraction wraps in two's complement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                    end
                end
                S_M_AC:  r_acc_re <= w_prod_ext;
                S_M_BD:  r_acc_re <= r_acc_re - w_prod_ext;
                S_M_AD:  r_acc_im <= w_prod_ext;
                S_M_BC:  r_acc_im <= r_acc_im + w_prod_ext;
                default: begin
                    r_acc_re <= r_acc_re;
                    r_acc_im <= r_acc_im;
                end
            endcase
        end
    end

    // Results come straight from the accumulators, so they hold in DONE.
    assign out_re = r_acc_re;
    assign out_im = r_acc_im;

endmodule
`default_nettype wire

// File: tb/tb_cmplx_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmplx_mul_seq
//  Description : Scoreboard bench for cmplx_mul_seq with a behavioural
//                WxW multiplier driving mul_p.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmplx_mul_seq;

    localparam int W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [W-1:0]     in_c;
    logic [W-1:0]     in_d;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_p;
    logic             out_valid;
    logic             out_ready;
    logic [2*W:0]     out_re;
    logic [2*W:0]     out_im;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_results = 0;
    bit t6_mode  = 1'b0;

    logic [4*W+1:0] sb_q[$];

    cmplx_mul_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .busy      (busy)
    );

    // Behavioural shared multiplier.
    assign mul_p = mul_a * mul_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4*W+1:0] model(input logic [W-1:0] a, b, c, d);
        int re;
        int im;
        logic [2*W:0] re_v;
        logic [2*W:0] im_v;
        re   = int'(a) * int'(c) - int'(b) * int'(d);
        im   = int'(a) * int'(d) + int'(b) * int'(c);
        re_v = re[2*W:0];
        im_v = im[2*W:0];
        return {re_v, im_v};
    endfunction

    // Monitor: push at acceptance, pop and compare at result handshake.
    int  acc_cyc   = 0;
    int  last_acc  = 0;
    bit  have_acc  = 1'b0;
    bit  prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [4*W+1:0] e;
        if (!t6_mode) have_acc = 1'b0;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb_q.push_back(model(in_a, in_b, in_c, in_d));
                if (t6_mode && have_acc) check("t6_issue_interval", 64'(cyc - last_acc), 64'd6);
                last_acc = cyc;
                acc_cyc  = cyc;
                have_acc = 1'b1;
            end
            if (out_valid && !prev_valid) check("valid_latency", 64'(cyc - acc_cyc), 64'd5);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_re", 64'(out_re), 64'(e[4*W+1:2*W+1]));
                    check("out_im", 64'(out_im), 64'(e[2*W:0]));
                    n_results++;
                end
            end
        end
        prev_valid = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_c = W'($urandom);
        in_d = W'($urandom);
    endtask

    // Wait (bounded) until the block is idle with no pending result.
    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready && !out_valid) done = 1'b1;
            else tick();
        end
        if (!done) check(tag, 64'd0, 64'd1);
    endtask

    // Present one operand set, accept it, then optionally wait for completion.
    task automatic run_op(input logic [W-1:0] a, b, c, d, input bit wait_done);
        in_a = a; in_b = b; in_c = c; in_d = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        if (wait_done) drain("op_timeout");
    endtask

    initial begin
        int base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0;
        tick(); tick();

        // Reset state
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_out_re",    64'(out_re),    64'd0);
        check("rst_out_im",    64'(out_im),    64'd0);
        check("rst_mul_a",     64'(mul_a),     64'd0);
        check("rst_mul_b",     64'(mul_b),     64'd0);
        rst = 1'b0;
        tick();

        // T1 basic, with multiplier operand sequence
        run_op(8'd3, 8'd2, 8'd5, 8'd4, 1'b0);
        check("t1_busy",     64'(busy),     64'd1);
        check("t1_in_ready", 64'(in_ready), 64'd0);
        check("t1_ma0", 64'(mul_a), 64'd3); check("t1_mb0", 64'(mul_b), 64'd5); tick();
        check("t1_ma1", 64'(mul_a), 64'd2); check("t1_mb1", 64'(mul_b), 64'd4); tick();
        check("t1_ma2", 64'(mul_a), 64'd3); check("t1_mb2", 64'(mul_b), 64'd4); tick();
        check("t1_ma3", 64'(mul_a), 64'd2); check("t1_mb3", 64'(mul_b), 64'd5); tick();
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_re", 64'(out_re), 64'd7);
        check("t1_im", 64'(out_im), 64'd22);
        check("t1_done_mul_a", 64'(mul_a), 64'd0);
        drain("t1_timeout");

        // T2 max magnitude, T3 negative real part
        run_op(8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
        run_op(8'd0, 8'd255, 8'd0, 8'd255, 1'b1);

        // T4 backpressure
        out_ready = 1'b0;
        run_op(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
        tick(); tick(); tick(); tick();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            scramble();
            check("t4_out_valid", 64'(out_valid), 64'd1);
            check("t4_in_ready",  64'(in_ready),  64'd0);
            check("t4_re", 64'(out_re), 64'h1FE0C);
            check("t4_im", 64'(out_im), 64'd1000);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_release_in_ready",  64'(in_ready),  64'd1);
        check("t4_release_out_valid", 64'(out_valid), 64'd0);

        // T5 reset while in M_AD
        run_op(8'd7, 8'd8, 8'd9, 8'd6, 1'b0);
        tick(); tick();
        check("t5_in_m_ad_mul_b", 64'(mul_b), 64'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_in_ready",  64'(in_ready),  64'd1);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_busy",      64'(busy),      64'd0);
        check("t5_out_re",    64'(out_re),    64'd0);
        check("t5_out_im",    64'(out_im),    64'd0);
        run_op(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);

        // T6 back-to-back with in_valid held high, operands churning every cycle
        t6_mode  = 1'b1;
        base     = n_results;
        scramble();
        in_valid = 1'b1;
        for (int i = 0; i < 36; i++) begin
            tick();
            scramble();
        end
        in_valid = 1'b0;
        drain("t6_timeout");
        check("t6_result_count", 64'(n_results - base), 64'd6);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
